// File: rtl/veririsc_pkg.sv
// rtl/veririsc_pkg.sv - VeriRISC opcode and phase types shared by the sequencer files
package veririsc_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Instructions that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/veririsc_sequencer_if.sv
// rtl/veririsc_sequencer_if.sv - sequencer control/strobe bundle; SEQ_SINGLE_STEP_EN adds step_mode/step
interface veririsc_sequencer_if;
    import veririsc_pkg::*;

    logic             enab;
    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             mem_ready;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step_mode;
    logic             step;
`endif
    logic             sel;
    logic             rd;
    logic             wr;
    logic             ld_ir;
    logic             ld_ac;
    logic             inc_pc;
    logic             ld_pc;
    logic             data_e;
    logic             halt;
    logic             mem_err;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  step_mode, step,
`endif
        input  enab, opcode, zero, mem_ready,
        output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, mem_err
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output step_mode, step,
`endif
        output enab, opcode, zero, mem_ready,
        input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, mem_err
    );

endinterface

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational phase/opcode decode into the nine datapath strobes
module seq_decode
    import veririsc_pkg::*;
(
    input  phase_t  phase,
    input  opcode_t opc,
    input  logic    zero,
    input  logic    halted,
    output logic    sel,
    output logic    rd,
    output logic    wr,
    output logic    ld_ir,
    output logic    ld_ac,
    output logic    inc_pc,
    output logic    ld_pc,
    output logic    data_e,
    output logic    halt
);

    logic aluop;
    assign aluop = is_aluop(opc);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        halt   = halted;
        if (!halted) begin
            case (phase)
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR:    inc_pc = 1'b1;
                OP_FETCH:   rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opc == SKZ) && zero;
                    ld_pc  = (opc == JMP);
                    data_e = (opc == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opc == JMP);
                    wr     = (opc == STO);
                    data_e = (opc == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/veririsc_sequencer.sv
// rtl/veririsc_sequencer.sv - VeriRISC 8-phase sequencer with memory-wait timeout and sticky halt
// Optional single-step control via SEQ_SINGLE_STEP_EN.
module veririsc_sequencer
    import veririsc_pkg::*;
#(
    parameter int STALL_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    veririsc_sequencer_if.master  bus
);

    phase_t     phase, phase_nxt;
    opcode_t    opc_q, opc_nxt;
    logic [7:0] stall_cnt, cnt_nxt;
    logic       halted, halted_nxt;
    logic       mem_err_q, err_nxt;

    logic waiting, stalled, timeout, advance, step_ok;

    // Phases that hold until memory acknowledges the access.
    assign waiting = (phase == INST_FETCH)
                   || ((phase == OP_FETCH) && is_aluop(opc_q))
                   || ((phase == STORE) && (opc_q == STO));
    assign stalled = bus.enab && !halted && waiting && !bus.mem_ready;
    assign timeout = stalled && (stall_cnt == 8'(STALL_TIMEOUT - 1));
    assign advance = bus.enab && !halted && !(waiting && !bus.mem_ready) && step_ok;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q, step_pend, step_rise, pend_nxt;

    assign step_rise = bus.step && !step_q;
    // A step edge seen mid-instruction is remembered for the next INST_ADDR.
    assign step_ok   = !bus.step_mode || (phase != INST_ADDR) || step_rise || step_pend;
    assign pend_nxt  = bus.step_mode && (step_pend || step_rise)
                       && !(advance && (phase == INST_ADDR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q    <= bus.step;
            step_pend <= pend_nxt;
        end
    end
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= INST_ADDR;
            opc_q     <= HLT;
            stall_cnt <= 8'd0;
            halted    <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            opc_q     <= opc_nxt;
            stall_cnt <= cnt_nxt;
            halted    <= halted_nxt;
            mem_err_q <= err_nxt;
        end
    end

    always_comb begin
        phase_nxt  = phase;
        opc_nxt    = opc_q;
        cnt_nxt    = stall_cnt;
        halted_nxt = halted;
        err_nxt    = mem_err_q;
        if (advance) begin
            phase_nxt = phase_t'(3'(phase + 3'd1));
            cnt_nxt   = 8'd0;
            if (phase == INST_LOAD) begin
                opc_nxt = opcode_t'(bus.opcode);
            end
            if ((phase == OP_ADDR) && (opc_q == HLT)) begin
                halted_nxt = 1'b1;
            end
        end else if (timeout) begin
            err_nxt    = 1'b1;
            halted_nxt = 1'b1;
        end else if (stalled) begin
            cnt_nxt = stall_cnt + 8'd1;
        end
    end

    seq_decode u_decode (
        .phase  (phase),
        .opc    (opc_q),
        .zero   (bus.zero),
        .halted (halted),
        .sel    (bus.sel),
        .rd     (bus.rd),
        .wr     (bus.wr),
        .ld_ir  (bus.ld_ir),
        .ld_ac  (bus.ld_ac),
        .inc_pc (bus.inc_pc),
        .ld_pc  (bus.ld_pc),
        .data_e (bus.data_e),
        .halt   (bus.halt)
    );

    assign bus.mem_err = mem_err_q;

endmodule
